// File: rtl/cpu_pkg.sv
// Shared CPU constants: IR bit positions for the register-I/O instructions
// and the default I/O data width.
package cpu_pkg;
    localparam int IO_INP     = 11;
    localparam int IO_OUT     = 10;
    localparam int IO_SKI     = 9;
    localparam int IO_SKO     = 8;
    localparam int IO_ION     = 7;
    localparam int IO_IOF     = 6;
    localparam int DATA_W_DEF = 8;
endpackage

// File: rtl/io_interrupt_unit.sv
// I/O and interrupt block: INPR/OUTR with device handshakes, FGI/FGO flags,
// skip request, interrupt enable and the interrupt-pending flag R.
module io_interrupt_unit
    import cpu_pkg::*;
#(
    parameter int       DATA_W  = DATA_W_DEF,
    parameter bit       FGO_RST = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [15:0]       ir,
    input  logic              io_exec,
    input  logic [DATA_W-1:0] ac_low,
    input  logic              sample_en,
    input  logic              int_done,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] inpr,
    output logic              skip,
    output logic              ien,
    output logic              r_flag,
    output logic              out_overrun
);
    logic [DATA_W-1:0] inpr_q, inpr_d, outr_q, outr_d;
    logic fgi_q, fgi_d, fgo_q, fgo_d, out_valid_q, out_valid_d;
    logic ien_q, ien_d, r_q, r_d, overrun_q, overrun_d;
    logic inp, outp, ski, sko, ion, iof, accept, dev_take;

    logic unused_ir;
    assign unused_ir = ^{ir[15:12], ir[5:0]};

    always_comb begin
        inp      = io_exec & ir[IO_INP];
        outp     = io_exec & ir[IO_OUT];
        ski      = io_exec & ir[IO_SKI];
        sko      = io_exec & ir[IO_SKO];
        ion      = io_exec & ir[IO_ION];
        iof      = io_exec & ir[IO_IOF];
        accept   = in_valid & ~fgi_q;
        dev_take = out_valid_q & out_ready;

        inpr_d = accept ? in_data : inpr_q;
        fgi_d  = fgi_q;
        if (accept)   fgi_d = 1'b1;
        else if (inp) fgi_d = 1'b0;

        // An OUT that lands on a cycle with a pending byte is dropped, even if
        // the device takes that byte on the same edge.
        outr_d      = outr_q;
        out_valid_d = out_valid_q;
        fgo_d       = fgo_q;
        overrun_d   = overrun_q;
        if (dev_take) begin
            out_valid_d = 1'b0;
            fgo_d       = 1'b1;
        end
        if (outp && !out_valid_q) begin
            outr_d      = ac_low;
            out_valid_d = 1'b1;
            fgo_d       = 1'b0;
        end
        if (outp && out_valid_q) overrun_d = 1'b1;

        ien_d = ien_q;
        if (int_done)  ien_d = 1'b0;
        else if (iof)  ien_d = 1'b0;
        else if (ion)  ien_d = 1'b1;

        r_d = r_q;
        if (int_done) r_d = 1'b0;
        else if (sample_en && ien_q && (fgi_q || fgo_q) && !r_q) r_d = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inpr_q      <= '0;
            outr_q      <= '0;
            fgi_q       <= 1'b0;
            fgo_q       <= FGO_RST;
            out_valid_q <= 1'b0;
            ien_q       <= 1'b0;
            r_q         <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            inpr_q      <= inpr_d;
            outr_q      <= outr_d;
            fgi_q       <= fgi_d;
            fgo_q       <= fgo_d;
            out_valid_q <= out_valid_d;
            ien_q       <= ien_d;
            r_q         <= r_d;
            overrun_q   <= overrun_d;
        end
    end

    assign in_ready    = ~fgi_q;
    assign out_data    = outr_q;
    assign out_valid   = out_valid_q;
    assign inpr        = inpr_q;
    assign skip        = (ski & fgi_q) | (sko & fgo_q);
    assign ien         = ien_q;
    assign r_flag      = r_q;
    assign out_overrun = overrun_q;
endmodule

// File: tb/tb_io_interrupt_unit.sv
// Scoreboard bench for io_interrupt_unit: expectations queued with stimulus,
// popped and compared once the DUT has reacted.
module tb_io_interrupt_unit;
    logic        clk = 1'b0, rst = 1'b1;
    logic [15:0] ir = 16'h0;
    logic        io_exec = 1'b0, sample_en = 1'b0, int_done = 1'b0;
    logic [7:0]  ac_low = 8'h0, in_data = 8'h0;
    logic        in_valid = 1'b0, out_ready = 1'b0;
    logic        in_ready, out_valid, skip, ien, r_flag, out_overrun;
    logic [7:0]  out_data, inpr;

    int checks = 0, fails = 0;
    logic [7:0] sb[$];
    logic [7:0] e;

    io_interrupt_unit #(.DATA_W(8), .FGO_RST(1'b1)) dut (
        .clk(clk), .rst(rst), .ir(ir), .io_exec(io_exec), .ac_low(ac_low),
        .sample_en(sample_en), .int_done(int_done), .in_data(in_data),
        .in_valid(in_valid), .in_ready(in_ready), .out_data(out_data),
        .out_valid(out_valid), .out_ready(out_ready), .inpr(inpr), .skip(skip),
        .ien(ien), .r_flag(r_flag), .out_overrun(out_overrun)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; tick(); tick();
        sb.push_back(8'h00); sb.push_back(8'h00); sb.push_back(8'h01);
        sb.push_back(8'h00); sb.push_back(8'h00); sb.push_back(8'h00); sb.push_back(8'h00);
        e = sb.pop_front(); checks++; if (inpr !== e) begin fails++; $display("FAIL rst_inpr: got %h want %h", inpr, e); end
        e = sb.pop_front(); checks++; if (out_data !== e) begin fails++; $display("FAIL rst_outr: got %h want %h", out_data, e); end
        e = sb.pop_front(); checks++; if (in_ready !== e[0]) begin fails++; $display("FAIL rst_in_ready: got %b want %b", in_ready, e[0]); end
        e = sb.pop_front(); checks++; if (out_valid !== e[0]) begin fails++; $display("FAIL rst_out_valid: got %b want %b", out_valid, e[0]); end
        e = sb.pop_front(); checks++; if (ien !== e[0]) begin fails++; $display("FAIL rst_ien: got %b want %b", ien, e[0]); end
        e = sb.pop_front(); checks++; if (r_flag !== e[0]) begin fails++; $display("FAIL rst_r: got %b want %b", r_flag, e[0]); end
        e = sb.pop_front(); checks++; if (out_overrun !== e[0]) begin fails++; $display("FAIL rst_overrun: got %b want %b", out_overrun, e[0]); end
        rst = 1'b0; tick();
        // FGO is only visible through SKO
        ir = 16'hF100; io_exec = 1'b1; sb.push_back(8'h01); #1;
        e = sb.pop_front(); checks++; if (skip !== e[0]) begin fails++; $display("FAIL rst_fgo_sko: got %b want %b", skip, e[0]); end
        io_exec = 1'b0; ir = 16'h0;
    endtask

    task automatic test_input();
        in_valid = 1'b1; in_data = 8'hA5;
        sb.push_back(8'hA5); sb.push_back(8'h00);
        tick();
        e = sb.pop_front(); checks++; if (inpr !== e) begin fails++; $display("FAIL in_inpr_a5: got %h want %h", inpr, e); end
        e = sb.pop_front(); checks++; if (in_ready !== e[0]) begin fails++; $display("FAIL in_ready_full: got %b want %b", in_ready, e[0]); end
        in_data = 8'h3C; tick();
        sb.push_back(8'hA5);
        e = sb.pop_front(); checks++; if (inpr !== e) begin fails++; $display("FAIL in_hold_full: got %h want %h", inpr, e); end
        in_valid = 1'b0; ir = 16'hF800; io_exec = 1'b1;
        sb.push_back(8'h01); sb.push_back(8'hA5);
        tick(); io_exec = 1'b0; ir = 16'h0;
        e = sb.pop_front(); checks++; if (in_ready !== e[0]) begin fails++; $display("FAIL in_inp_clear: got %b want %b", in_ready, e[0]); end
        e = sb.pop_front(); checks++; if (inpr !== e) begin fails++; $display("FAIL in_inp_keep: got %h want %h", inpr, e); end
        in_valid = 1'b1; in_data = 8'h3C;
        sb.push_back(8'h3C); sb.push_back(8'h00);
        tick(); in_valid = 1'b0;
        e = sb.pop_front(); checks++; if (inpr !== e) begin fails++; $display("FAIL in_second: got %h want %h", inpr, e); end
        e = sb.pop_front(); checks++; if (in_ready !== e[0]) begin fails++; $display("FAIL in_second_rdy: got %b want %b", in_ready, e[0]); end
    endtask

    task automatic test_skip();
        ir = 16'hF200; sb.push_back(8'h00); #1;
        e = sb.pop_front(); checks++; if (skip !== e[0]) begin fails++; $display("FAIL ski_no_exec: got %b want %b", skip, e[0]); end
        io_exec = 1'b1; sb.push_back(8'h01); #1;
        e = sb.pop_front(); checks++; if (skip !== e[0]) begin fails++; $display("FAIL ski_fgi1: got %b want %b", skip, e[0]); end
        ir = 16'hF800; tick();
        ir = 16'hF200; sb.push_back(8'h00); #1;
        e = sb.pop_front(); checks++; if (skip !== e[0]) begin fails++; $display("FAIL ski_fgi0: got %b want %b", skip, e[0]); end
        io_exec = 1'b0; ir = 16'h0;
    endtask

    task automatic test_output();
        ac_low = 8'h41; ir = 16'hF400; io_exec = 1'b1; out_ready = 1'b0;
        tick(); io_exec = 1'b0;
        sb.push_back(8'h01); sb.push_back(8'h41);
        e = sb.pop_front(); checks++; if (out_valid !== e[0]) begin fails++; $display("FAIL out_valid_set: got %b want %b", out_valid, e[0]); end
        e = sb.pop_front(); checks++; if (out_data !== e) begin fails++; $display("FAIL out_data_41: got %h want %h", out_data, e); end
        ir = 16'hF100; io_exec = 1'b1; sb.push_back(8'h00); #1;
        e = sb.pop_front(); checks++; if (skip !== e[0]) begin fails++; $display("FAIL sko_fgo0: got %b want %b", skip, e[0]); end
        io_exec = 1'b0; ac_low = 8'h99;
        for (int i = 0; i < 3; i++) begin
            tick(); sb.push_back(8'h41); sb.push_back(8'h01);
            e = sb.pop_front(); checks++; if (out_data !== e) begin fails++; $display("FAIL out_stable%0d: got %h want %h", i, out_data, e); end
            e = sb.pop_front(); checks++; if (out_valid !== e[0]) begin fails++; $display("FAIL out_hold%0d: got %b want %b", i, out_valid, e[0]); end
        end
        ac_low = 8'h77; ir = 16'hF400; io_exec = 1'b1;
        tick(); io_exec = 1'b0;
        sb.push_back(8'h01); sb.push_back(8'h41);
        e = sb.pop_front(); checks++; if (out_overrun !== e[0]) begin fails++; $display("FAIL out_overrun: got %b want %b", out_overrun, e[0]); end
        e = sb.pop_front(); checks++; if (out_data !== e) begin fails++; $display("FAIL out_overrun_keep: got %h want %h", out_data, e); end
        out_ready = 1'b1; tick(); out_ready = 1'b0;
        sb.push_back(8'h00); sb.push_back(8'h01);
        e = sb.pop_front(); checks++; if (out_valid !== e[0]) begin fails++; $display("FAIL out_taken: got %b want %b", out_valid, e[0]); end
        ir = 16'hF100; io_exec = 1'b1; #1;
        e = sb.pop_front(); checks++; if (skip !== e[0]) begin fails++; $display("FAIL sko_fgo1: got %b want %b", skip, e[0]); end
        // OUT coinciding with the device accepting the pending byte
        ac_low = 8'h55; ir = 16'hF400; tick();
        ac_low = 8'h66; out_ready = 1'b1; tick(); io_exec = 1'b0; out_ready = 1'b0;
        sb.push_back(8'h00); sb.push_back(8'h55);
        e = sb.pop_front(); checks++; if (out_valid !== e[0]) begin fails++; $display("FAIL out_race_valid: got %b want %b", out_valid, e[0]); end
        e = sb.pop_front(); checks++; if (out_data !== e) begin fails++; $display("FAIL out_race_data: got %h want %h", out_data, e); end
        ir = 16'hF100; io_exec = 1'b1; sb.push_back(8'h01); #1;
        e = sb.pop_front(); checks++; if (skip !== e[0]) begin fails++; $display("FAIL out_race_fgo: got %b want %b", skip, e[0]); end
        io_exec = 1'b0; ir = 16'h0;
    endtask

    task automatic test_interrupt();
        ir = 16'hF080; io_exec = 1'b1; sample_en = 1'b0;
        tick(); io_exec = 1'b0; ir = 16'h0;
        sb.push_back(8'h01); sb.push_back(8'h00);
        e = sb.pop_front(); checks++; if (ien !== e[0]) begin fails++; $display("FAIL int_ion: got %b want %b", ien, e[0]); end
        tick();
        e = sb.pop_front(); checks++; if (r_flag !== e[0]) begin fails++; $display("FAIL int_no_sample: got %b want %b", r_flag, e[0]); end
        sample_en = 1'b1; tick(); sample_en = 1'b0;
        sb.push_back(8'h01);
        e = sb.pop_front(); checks++; if (r_flag !== e[0]) begin fails++; $display("FAIL int_r_set: got %b want %b", r_flag, e[0]); end
        tick(); tick(); sb.push_back(8'h01);
        e = sb.pop_front(); checks++; if (r_flag !== e[0]) begin fails++; $display("FAIL int_r_hold: got %b want %b", r_flag, e[0]); end
        sample_en = 1'b1; int_done = 1'b1; tick(); int_done = 1'b0;
        sb.push_back(8'h00); sb.push_back(8'h00);
        e = sb.pop_front(); checks++; if (r_flag !== e[0]) begin fails++; $display("FAIL int_done_r: got %b want %b", r_flag, e[0]); end
        e = sb.pop_front(); checks++; if (ien !== e[0]) begin fails++; $display("FAIL int_done_ien: got %b want %b", ien, e[0]); end
        tick(); tick(); sb.push_back(8'h00);
        e = sb.pop_front(); checks++; if (r_flag !== e[0]) begin fails++; $display("FAIL int_no_reset: got %b want %b", r_flag, e[0]); end
        sample_en = 1'b0;
    endtask

    task automatic test_priority();
        ir = 16'hF080; io_exec = 1'b1; int_done = 1'b1;
        tick(); int_done = 1'b0;
        sb.push_back(8'h00);
        e = sb.pop_front(); checks++; if (ien !== e[0]) begin fails++; $display("FAIL pri_done_ion: got %b want %b", ien, e[0]); end
        ir = 16'hF0C0; tick();
        sb.push_back(8'h00);
        e = sb.pop_front(); checks++; if (ien !== e[0]) begin fails++; $display("FAIL pri_iof_ion: got %b want %b", ien, e[0]); end
        io_exec = 1'b0; in_valid = 1'b1; in_data = 8'h5A; tick(); in_valid = 1'b0;
        ir = 16'hF080; io_exec = 1'b1; tick();
        ir = 16'hF040; tick(); io_exec = 1'b0; ir = 16'h0;
        sb.push_back(8'h00);
        e = sb.pop_front(); checks++; if (ien !== e[0]) begin fails++; $display("FAIL pri_iof: got %b want %b", ien, e[0]); end
        sample_en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick(); sb.push_back(8'h00);
            e = sb.pop_front(); checks++; if (r_flag !== e[0]) begin fails++; $display("FAIL pri_r_off%0d: got %b want %b", i, r_flag, e[0]); end
        end
        sample_en = 1'b0;
    endtask

    task automatic test_mid_reset();
        ac_low = 8'hC3; ir = 16'hF400; io_exec = 1'b1; tick(); io_exec = 1'b0; ir = 16'h0;
        rst = 1'b1; #1;
        sb.push_back(8'h00); sb.push_back(8'h00); sb.push_back(8'h01); sb.push_back(8'h00);
        e = sb.pop_front(); checks++; if (out_valid !== e[0]) begin fails++; $display("FAIL mid_out_valid: got %b want %b", out_valid, e[0]); end
        e = sb.pop_front(); checks++; if (out_overrun !== e[0]) begin fails++; $display("FAIL mid_overrun: got %b want %b", out_overrun, e[0]); end
        e = sb.pop_front(); checks++; if (in_ready !== e[0]) begin fails++; $display("FAIL mid_in_ready: got %b want %b", in_ready, e[0]); end
        e = sb.pop_front(); checks++; if (out_data !== e) begin fails++; $display("FAIL mid_outr: got %h want %h", out_data, e); end
        tick(); rst = 1'b0; tick();
        ir = 16'hF100; io_exec = 1'b1; sb.push_back(8'h01); #1;
        e = sb.pop_front(); checks++; if (skip !== e[0]) begin fails++; $display("FAIL mid_fgo: got %b want %b", skip, e[0]); end
        io_exec = 1'b0; ir = 16'h0;
    endtask

    initial begin
        test_reset();
        test_input();
        test_skip();
        test_output();
        test_interrupt();
        test_priority();
        test_mid_reset();
        checks++;
        if (sb.size() != 0) begin fails++; $display("FAIL sb_drain: got %0d want 0", sb.size()); end
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
